echo_enq_scheduler: RTL
=======================

// Module: echo_enq_scheduler
// PURPOSE
//  - Shares one Fifo1 int echo datapath (enq / first / deq methods) between NREQ requesters.
//  - Round-robin grants the enq method to one requester per cycle.
//  - Drains the FIFO into the EchoIndication echo method.
//  - Tags every echo with the requester ID that enqueued it.
// PARAMETERS
//  NREQ       4   number of requesters, >=2
//  DATA_W     32  width of echoed value
//  TAG_DEPTH  4   outstanding-tag capacity, power of 2, >=2
//  ID_W       $clog2(NREQ)  requester-ID width (derived, do not override)
// PORTS
//  CLK            in   1             clock
//  RST            in   1             synchronous reset, active-high
//  req_want       in   NREQ          requester i wants to enq this cycle
//  req__RDY       out  NREQ          one-hot grant; bit i = enq open to requester i
//  req__ENA       in   NREQ          requester i fires enq (legal only with its RDY)
//  req_v          in   NREQ*DATA_W   packed values; slice i belongs to requester i
//  fifo_enq__RDY  in   1             Fifo1 enq ready
//  fifo_enq__ENA  out  1             Fifo1 enq fire
//  fifo_enq_v     out  DATA_W        Fifo1 enq data
//  fifo_first__RDY in  1             Fifo1 first valid
//  fifo_first     in   DATA_W        Fifo1 head value
//  fifo_deq__RDY  in   1             Fifo1 deq ready
//  fifo_deq__ENA  out  1             Fifo1 deq fire
//  ind_echo__RDY  in   1             indication sink ready
//  ind_echo__ENA  out  1             indication fire
//  ind_echo_v     out  DATA_W        echoed value
//  ind_echo_id    out  ID_W          requester ID that originated the value
//  tag_count      out  $clog2(TAG_DEPTH)+1  outstanding tags
// BEHAVIOUR
//  - Reset: rr_ptr=0, tag wr/rd ptrs=0, tag_count=0.
//  - While RST is high, all __RDY/__ENA outputs are 0 and ind_echo_v/ind_echo_id are 0.
//  - enq_ok = fifo_enq__RDY & (tag_count<TAG_DEPTH).
//  - Full blocks enq even if a pop occurs in the same cycle; there is no bypass.
//  - Winner = first i with req_want[i], scanning from rr_ptr upward with wrap mod NREQ.
//  - req__RDY = onehot(winner) when enq_ok and any want; otherwise 0.
//  - All RDY outputs are combinational from current inputs and state.
//  - Enq fire = |(req__ENA & req__RDY).
//  - On enq fire, in the same cycle: fifo_enq__ENA=1 and fifo_enq_v=req_v slice of the winner.
//  - On enq fire, at the next edge: winner ID is pushed into the tag queue and rr_ptr <= (winner+1) mod NREQ.
//  - With no fire, rr_ptr holds.
//  - req__ENA bits without a matching RDY are ignored and have no side effect.
//  - Drain fire = fifo_first__RDY & fifo_deq__RDY & ind_echo__RDY & (tag_count!=0).
//  - Drain fire is combinational, zero latency: fifo_deq__ENA = ind_echo__ENA = drain fire.
//  - ind_echo_v=fifo_first and ind_echo_id=tag head; both are 0 when not firing.
//  - Tag pop on drain fire.
//  - Simultaneous push and pop: tag_count unchanged, both pointers advance.
//  - Pointers wrap mod TAG_DEPTH.
//  - If FIFO data is present with tag_count==0 (foreign data), it is not drained.
//  - Reset mid-operation: all tags are discarded and the FIFO is not flushed.
//  - The system resets the Fifo1 together with this block.
// CONFIGURATION
//  - ECHO_SCHED_STATS_EN defined adds outputs:
//    - stat_grants[NREQ*16]: per-requester enq-fire counters, saturating at 16'hFFFF.
//    - stat_stall[16]: cycles where any want is set and enq_ok=0, saturating.
//    - stat_proto_err: sticky bit, set when req__ENA[i] is seen without req__RDY[i].
//    - All stats clear on RST.
//  - Undefined: these ports and counters are absent and behaviour is otherwise identical.
// STRUCTURE
//  - Package echo_sched_pkg holds:
//    - localparam defaults: NREQ, DATA_W, TAG_DEPTH.
//    - function id_w(n) = $clog2(n).
//    - typedef echo_id_t for the requester ID.
//  - Sub-module echo_tag_fifo holds the tag queue:
//    - parameters DEPTH, W.
//    - ports push, push_d, pop, head, count, full, empty.
//    - synchronous active-high reset.
//  - Top-level holds the round-robin arbiter, enq mux, drain logic and optional stats.
// TESTING
//  - Single requester: want[0]=1, ENA on RDY, v=22.
//    - Required: fifo_enq_v=22 in the same cycle.
//    - Required: next drain gives ind_echo_v=22, ind_echo_id=0.
//  - All 4 requesters want continuously, FIFO always ready.
//    - Required: grants rotate 0,1,2,3,0.
//    - Required: ind_echo_id sequence 0,1,2,3,0.
//  - Hold ind_echo__RDY=0 until tag_count=4.
//    - Required: req__RDY=0 while full.
//    - Required: after release, IDs drain in enq order and tag_count returns to 0.
//  - Full queue, same-cycle enq request and drain.
//    - Required: no grant that cycle.
//    - Required: next cycle grant allowed and tag_count=3 then 4.
//  - RST asserted with 3 tags outstanding.
//    - Required: next cycle tag_count=0, rr_ptr=0, all ENA/RDY=0.
//  - ECHO_SCHED_STATS_EN: drive req__ENA[2] with no RDY.
//    - Required: stat_proto_err=1, no enq, stat_grants[2]=0.

Source files
------------

// File: rtl/echo_sched_pkg.sv
// Shared defaults, ID-width helper and requester-ID type for the echo enq scheduler.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package echo_sched_pkg;

    localparam int NREQ      = 4;
    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 4;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

    typedef logic [id_w(NREQ)-1:0] echo_id_t;

endpackage

// File: rtl/echo_tag_fifo.sv
// Circular queue of requester IDs, one per value sitting in the shared echo FIFO.
// Latency: push visible at head/count one cycle later; head is combinational from the read pointer.
// Backpressure: push ignored when full, pop ignored when empty; owner gates both with full/empty.
module echo_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic [W-1:0] push_d,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [PW:0]  count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_d;
    end

endmodule

// File: rtl/echo_enq_scheduler.sv
// Round-robin shares one echo FIFO enq port among NREQ requesters and drains it tagged by ID; ECHO_SCHED_STATS_EN adds counters.
// Latency: grant, enq and drain are all combinational in the same cycle; tags and rr pointer update at the edge.
// Backpressure: no grant when FIFO enq not ready or tag queue full; drain waits on FIFO head, deq and sink ready.
module echo_enq_scheduler
    import echo_sched_pkg::*;
#(
    parameter int NREQ      = echo_sched_pkg::NREQ,
    parameter int DATA_W    = echo_sched_pkg::DATA_W,
    parameter int TAG_DEPTH = echo_sched_pkg::TAG_DEPTH,
    localparam int ID_W     = echo_sched_pkg::id_w(NREQ),
    localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_want,
    output logic [NREQ-1:0]        req__RDY,
    input  logic [NREQ-1:0]        req__ENA,
    input  logic [NREQ*DATA_W-1:0] req_v,
    input  logic                   fifo_enq__RDY,
    output logic                   fifo_enq__ENA,
    output logic [DATA_W-1:0]      fifo_enq_v,
    input  logic                   fifo_first__RDY,
    input  logic [DATA_W-1:0]      fifo_first,
    input  logic                   fifo_deq__RDY,
    output logic                   fifo_deq__ENA,
    input  logic                   ind_echo__RDY,
    output logic                   ind_echo__ENA,
    output logic [DATA_W-1:0]      ind_echo_v,
    output logic [ID_W-1:0]        ind_echo_id,
    output logic [CW-1:0]          tag_count
`ifdef ECHO_SCHED_STATS_EN
    ,
    output logic [NREQ*16-1:0]     stat_grants,
    output logic [15:0]            stat_stall,
    output logic                   stat_proto_err
`endif
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   win_hi;
    logic [ID_W-1:0]   win_lo;
    logic              hi_found;
    logic              any_want;
    logic              enq_ok;
    logic              grant_vld;
    logic              enq_fire;
    logic              drain_fire;
    logic              tag_full;
    logic              tag_empty;
    logic [ID_W-1:0]   tag_head;
    logic [DATA_W-1:0] sel_v;

    // Lowest wanting index at or above rr_ptr wins; otherwise wrap to the lowest wanting index.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_want[i]) begin
                win_lo = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    win_hi   = ID_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        winner = hi_found ? win_hi : win_lo;
    end

    always_comb begin
        sel_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == ID_W'(i)) sel_v = req_v[i*DATA_W +: DATA_W];
        end
    end

    // A full tag queue blocks enq even if a drain frees a slot this cycle.
    assign any_want   = |req_want;
    assign enq_ok     = fifo_enq__RDY & ~tag_full;
    assign grant_vld  = ~RST & enq_ok & any_want;
    assign req__RDY   = grant_vld ? (NREQ'(1) << winner) : '0;
    assign enq_fire   = |(req__ENA & req__RDY);

    assign fifo_enq__ENA = enq_fire;
    assign fifo_enq_v    = enq_fire ? sel_v : '0;

    // Untagged (foreign) FIFO data is never drained.
    assign drain_fire    = ~RST & fifo_first__RDY & fifo_deq__RDY & ind_echo__RDY & ~tag_empty;
    assign fifo_deq__ENA = drain_fire;
    assign ind_echo__ENA = drain_fire;
    assign ind_echo_v    = drain_fire ? fifo_first : '0;
    assign ind_echo_id   = drain_fire ? tag_head : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (enq_fire) begin
            rr_ptr <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    echo_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ID_W)
    ) u_tags (
        .CLK    (CLK),
        .RST    (RST),
        .push   (enq_fire),
        .push_d (winner),
        .pop    (drain_fire),
        .head   (tag_head),
        .count  (tag_count),
        .full   (tag_full),
        .empty  (tag_empty)
    );

`ifdef ECHO_SCHED_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_grants    <= '0;
            stat_stall     <= '0;
            stat_proto_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (enq_fire && winner == ID_W'(i) && stat_grants[i*16 +: 16] != 16'hFFFF)
                    stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
            end
            if (any_want && !enq_ok && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
            if (|(req__ENA & ~req__RDY))
                stat_proto_err <= 1'b1;
        end
    end
`endif

endmodule
